mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one downstream memory port between the instruction-fetch side (I, read-only)
//  and the load/store side (D, read/write) of the 5-stage core.
//  Sits between the core's icache/dcache request outputs and the single memory bus.
//  One transaction outstanding at a time; round-robin on contention.
//  Supports cancelling an in-flight I fetch on branch/flush.
// PARAMETERS
//  ADDR_W  32  address width (AddrBus)
//  DATA_W  32  data width (DataBus/InstBus)
// PORTS
//  clk               in   1       clock, rising edge
//  rst               in   1       asynchronous, active-high reset
//  i_req_valid_i     in   1       I fetch request
//  i_addr_i          in   ADDR_W  I fetch address
//  i_flush_i         in   1       cancel any pending/in-flight I fetch
//  i_ready_o         out  1       I request accepted this cycle (valid&&ready)
//  i_data_valid_o    out  1       1-cycle pulse: i_data_o holds fetched instruction
//  i_data_o          out  DATA_W  fetched instruction
//  d_req_valid_i     in   1       D request
//  d_wen_i           in   1       1 = store, 0 = load
//  d_addr_i          in   ADDR_W  D address
//  d_wdata_i         in   DATA_W  store data
//  d_wlen_i          in   2       store size: 0=B, 1=H, 2=W
//  d_ready_o         out  1       D request accepted this cycle
//  d_data_valid_o    out  1       1-cycle pulse: load data / store ack
//  d_data_o          out  DATA_W  load data (0 on store ack)
//  mem_req_valid_o   out  1       downstream request valid
//  mem_wen_o         out  1       downstream write enable
//  mem_addr_o        out  ADDR_W  downstream address
//  mem_wdata_o       out  DATA_W  downstream write data
//  mem_wlen_o        out  2       downstream write size
//  mem_ready_i       in   1       downstream accepts request (valid&&ready)
//  mem_data_valid_i  in   1       downstream response (read data or write ack)
//  mem_data_i        in   DATA_W  downstream read data
//  busy_o            out  1       state != IDLE
// BEHAVIOUR
//  - States: IDLE, ISSUE, WAIT, RESP. Owner register own (I/D); last-grant register lg.
//  - Reset (async): state=IDLE, lg=I, all outputs 0, latched addr/data/wen/wlen = 0.
//  - IDLE: i_ready_o/d_ready_o are combinational grants, at most one high.
//      only one valid -> grant it; both valid -> grant side != lg.
//      i_flush_i high in IDLE blocks the I grant that cycle.
//      On grant: latch addr/wen/wdata/wlen (I: wen=0, wlen=0), own<=winner, lg<=winner,
//      -> ISSUE. No request -> stay IDLE.
//  - ISSUE: mem_req_valid_o=1 with latched fields, held stable; mem_ready_i -> WAIT.
//  - WAIT: mem_req_valid_o=0; mem_data_valid_i -> latch mem_data_i (0 if wen) -> RESP.
//      mem_data_valid_i in any state other than WAIT is ignored.
//  - RESP (1 cycle): pulse own's *_data_valid_o with the latched data -> IDLE.
//      Data outputs hold their value until the next RESP.
//  - Flush: i_flush_i in ISSUE/WAIT/RESP with own=I sets a cancel flag.
//      The downstream transaction still completes (no abort on the bus),
//      but i_data_valid_o is suppressed in RESP. The flag clears on entry to IDLE.
//  - Minimum latency: grant at cycle N, mem_req_valid_o at N+1; mem_ready_i at N+1
//      and mem_data_valid_i at N+2 give *_data_valid_o at N+3.
//  - Earliest next grant is the cycle after RESP (back-to-back period = 4 cycles).
//  - No grant is given while busy_o=1; requesters hold req_valid until ready.
//  - D side never cancelled. Reset mid-transaction drops it silently (no response).
// TESTING
//  1. I only: addr=0x8000_0000, mem ready immediately, data=0x0000_0013 one cycle later
//     -> i_data_valid_o pulse at N+3 with 0x13; mem_wen_o=0 throughout.
//  2. Both valid at reset-exit -> D granted first (lg=I).
//     Both held -> I next, then D: strict alternation I/D.
//  3. D store addr=0x10, wdata=0xDEADBEEF, wlen=2, mem_ready_i delayed 3 cycles
//     -> mem fields stable across stall; d_data_valid_o pulses once with d_data_o=0.
//  4. I fetch, i_flush_i asserted in WAIT -> bus transaction completes,
//     i_data_valid_o stays 0, busy_o drops, next D request granted normally.
//  5. mem_data_valid_i spuriously high in IDLE/ISSUE -> ignored, no data_valid pulse.
//  6. rst asserted during WAIT -> outputs 0 immediately (async); after release state=IDLE;
//     a late mem_data_valid_i is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the I/D request sides, the arbiter and the shared memory bus.
// Handshake: a request transfers on a cycle where valid && ready are both high; requesters hold valid and payload until then.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_ready;
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data;

    logic              d_req_valid;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_wlen;
    logic              d_ready;
    logic              d_data_valid;
    logic [DATA_W-1:0] d_data;

    logic              mem_req_valid;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_wlen;
    logic              mem_ready;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_addr, i_flush,
        output i_ready, i_data_valid, i_data,
        input  d_req_valid, d_wen, d_addr, d_wdata, d_wlen,
        output d_ready, d_data_valid, d_data,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wlen,
        input  mem_ready, mem_data_valid, mem_data,
        output busy
    );

    // Core requesters plus memory model side.
    modport master (
        output i_req_valid, i_addr, i_flush,
        input  i_ready, i_data_valid, i_data,
        output d_req_valid, d_wen, d_addr, d_wdata, d_wlen,
        input  d_ready, d_data_valid, d_data,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wlen,
        output mem_ready, mem_data_valid, mem_data,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store,
// one transaction at a time, round-robin on contention, with I-fetch cancel on flush.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t            state, state_next;
    logic              own_d, lg_d;   // 1 = D side, 0 = I side
    logic              cancel;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic [1:0]        wlen_q;
    logic [DATA_W-1:0] i_data_q, d_data_q;
    logic              grant_i, grant_d;
    logic              i_cand, d_cand;

    // Grants only exist in IDLE; on contention the side that did not win last time goes.
    always_comb begin
        i_cand  = bus.i_req_valid && !bus.i_flush;
        d_cand  = bus.d_req_valid;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && !rst) begin
            if (i_cand && d_cand) begin
                grant_d = !lg_d;
                grant_i = lg_d;
            end else begin
                grant_i = i_cand;
                grant_d = d_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_i || grant_d)  state_next = ISSUE;
            ISSUE:   if (bus.mem_ready)       state_next = WAIT;
            WAIT:    if (bus.mem_data_valid)  state_next = RESP;
            RESP:                             state_next = IDLE;
            default:                          state_next = IDLE;
        endcase

        bus.i_ready       = grant_i;
        bus.d_ready       = grant_d;
        bus.mem_req_valid = (state == ISSUE);
        bus.mem_wen       = (state == ISSUE) && wen_q;
        bus.mem_addr      = (state == ISSUE) ? addr_q  : '0;
        bus.mem_wdata     = (state == ISSUE) ? wdata_q : '0;
        bus.mem_wlen      = (state == ISSUE) ? wlen_q  : 2'd0;
        // A flush arriving in RESP itself also suppresses the fetch pulse.
        bus.i_data_valid  = (state == RESP) && !own_d && !cancel && !bus.i_flush;
        bus.d_data_valid  = (state == RESP) && own_d;
        bus.i_data        = i_data_q;
        bus.d_data        = d_data_q;
        bus.busy          = (state != IDLE);
        dbg_state         = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_d    <= 1'b0;
            lg_d     <= 1'b0;
            cancel   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            wlen_q   <= 2'd0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            if (grant_i || grant_d) begin
                own_d   <= grant_d;
                lg_d    <= grant_d;
                addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                wen_q   <= grant_d && bus.d_wen;
                wdata_q <= grant_d ? bus.d_wdata : '0;
                wlen_q  <= grant_d ? bus.d_wlen : 2'd0;
            end
            if (state == WAIT && bus.mem_data_valid) begin
                if (own_d) d_data_q <= wen_q ? '0 : bus.mem_data;
                else       i_data_q <= bus.mem_data;
            end
            // The bus transaction always completes; only the fetch response is dropped.
            if (state == RESP)
                cancel <= 1'b0;
            else if (state != IDLE && !own_d && bus.i_flush)
                cancel <= 1'b1;
        end
    end
endmodule
